// File: rtl/perceptron_weight_engine.sv
// rtl/perceptron_weight_engine.sv - perceptron weight store with built-in training
//
// Purpose:
//   Holds PERCEPTRON_NUMBER rows of WEIGHT_NUMBER signed saturating weights.
//   After reset the rows are cleared one per cycle. The predict path reads a
//   full row through a registered port. Training requests arrive over a
//   valid/ready handshake. When a request needs training, the engine applies
//   the perceptron rule to LANES weights per cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_en, rd_index     row read request
//   rd_valid            rd_weights/rd_conflict valid (one cycle after rd_en)
//   rd_weights          registered row contents (held while rd_valid=0)
//   rd_conflict         row returned was being trained at read time
//   train_valid/ready   training request handshake
//   train_index         row to train
//   train_history       global history used at prediction
//   train_sum           perceptron sum computed at prediction
//   train_taken         resolved branch outcome
//   train_done          one-cycle pulse when a request completes
//   train_applied       qualifies train_done: 1 = weights were modified
module perceptron_weight_engine #(
  parameter int PERCEPTRON_NUMBER = 64,
  parameter int HISTORY_SIZE      = 16,
  parameter int WEIGHT_NUMBER     = HISTORY_SIZE + 1,
  parameter int WIDTH             = 8,
  parameter int LANES             = 4,
  parameter int THETA             = 44,
  parameter int SUM_WIDTH         = WIDTH + $clog2(WEIGHT_NUMBER) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 rd_en,
  input  logic [$clog2(PERCEPTRON_NUMBER)-1:0] rd_index,
  output logic                                 rd_valid,
  output logic signed [WIDTH-1:0]              rd_weights [WEIGHT_NUMBER],
  output logic                                 rd_conflict,
  input  logic                                 train_valid,
  output logic                                 train_ready,
  input  logic [$clog2(PERCEPTRON_NUMBER)-1:0] train_index,
  input  logic [HISTORY_SIZE-1:0]              train_history,
  input  logic signed [SUM_WIDTH-1:0]          train_sum,
  input  logic                                 train_taken,
  output logic                                 train_done,
  output logic                                 train_applied
);

  localparam int IW     = $clog2(PERCEPTRON_NUMBER);
  localparam int GROUPS = (WEIGHT_NUMBER + LANES - 1) / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [GW-1:0]           LAST_GRP = GW'(GROUPS - 1);
  localparam logic [IW-1:0]           LAST_ROW = IW'(PERCEPTRON_NUMBER - 1);
  localparam logic signed [WIDTH-1:0] W_MAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] W_MIN    = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] row_q, row_d;
  logic [GW-1:0] grp_q, grp_d;
  logic          done_d, applied_d;

  logic [IW-1:0]           lat_idx_q;
  logic [HISTORY_SIZE-1:0] lat_hist_q;
  logic                    lat_taken_q;

  logic signed [WIDTH-1:0] mem [PERCEPTRON_NUMBER][WEIGHT_NUMBER];

  // ---------------------------------------------------------------------
  // Train decision
  // ---------------------------------------------------------------------
  // The magnitude is formed one bit wider so that the most-negative sum
  // still has a representable absolute value.
  logic                   sum_neg;
  logic signed [SUM_WIDTH:0] sum_ext;
  logic [SUM_WIDTH:0]     sum_abs;
  logic                   low_conf;
  logic                   mispredict;
  logic                   need_train;
  logic                   accept;

  assign sum_neg    = train_sum[SUM_WIDTH-1];
  assign sum_ext    = {train_sum[SUM_WIDTH-1], train_sum};
  assign sum_abs    = sum_neg ? (-sum_ext) : sum_ext;
  assign low_conf   = (sum_abs <= (SUM_WIDTH+1)'(THETA));
  // Predicted taken is sum >= 0, i.e. the sign bit clear.
  assign mispredict = (train_taken != !sum_neg);
  assign need_train = mispredict || low_conf;

  assign train_ready = (state_q == S_IDLE);
  assign accept      = train_valid && train_ready;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_CLEAR;
      row_q         <= '0;
      grp_q         <= '0;
      train_done    <= 1'b0;
      train_applied <= 1'b0;
      lat_idx_q     <= '0;
      lat_hist_q    <= '0;
      lat_taken_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      grp_q         <= grp_d;
      train_done    <= done_d;
      train_applied <= applied_d;
      if (accept) begin
        lat_idx_q   <= train_index;
        lat_hist_q  <= train_history;
        lat_taken_q <= train_taken;
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and done/applied strobes
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    grp_d     = grp_q;
    done_d    = 1'b0;
    applied_d = 1'b0;
    case (state_q)
      S_CLEAR: begin
        row_d = row_q + 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (accept) begin
          if (need_train) begin
            state_d = S_UPDATE;
            grp_d   = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_UPDATE: begin
        grp_d = grp_q + 1'b1;
        if (grp_q == LAST_GRP) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          applied_d = 1'b1;
        end
      end
      default: begin
        state_d = S_CLEAR;
        row_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Weight update datapath
  // ---------------------------------------------------------------------
  // x_pos[j] is 1 where the input to weight j is +1: the bias always, and
  // history bit j-1 for the others. The weight moves up when x agrees with
  // the outcome and down otherwise, sticking at the rails.
  logic [WEIGHT_NUMBER-1:0] x_pos;
  logic [WEIGHT_NUMBER-1:0] lane_en;
  logic signed [WIDTH-1:0]  upd_w [WEIGHT_NUMBER];

  assign x_pos = {lat_hist_q, 1'b1};

  always_comb begin
    for (int j = 0; j < WEIGHT_NUMBER; j++) begin
      lane_en[j] = (state_q == S_UPDATE) && (grp_q == GW'(j / LANES));
      upd_w[j]   = mem[lat_idx_q][j];
      if (x_pos[j] == lat_taken_q) begin
        if (mem[lat_idx_q][j] != W_MAX) begin
          upd_w[j] = mem[lat_idx_q][j] + WIDTH'(1);
        end
      end else begin
        if (mem[lat_idx_q][j] != W_MIN) begin
          upd_w[j] = mem[lat_idx_q][j] - WIDTH'(1);
        end
      end
    end
  end

  // Storage has no reset of its own; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) begin
        for (int j = 0; j < WEIGHT_NUMBER; j++) begin
          mem[row_q][j] <= '0;
        end
      end else begin
        for (int j = 0; j < WEIGHT_NUMBER; j++) begin
          if (lane_en[j]) begin
            mem[lat_idx_q][j] <= upd_w[j];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------
  // Nonblocking storage writes make a same-cycle read see pre-write values.
  logic rd_go;
  assign rd_go = rd_en && (state_q != S_CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid    <= 1'b0;
      rd_conflict <= 1'b0;
      for (int j = 0; j < WEIGHT_NUMBER; j++) begin
        rd_weights[j] <= '0;
      end
    end else begin
      rd_valid    <= rd_go;
      rd_conflict <= rd_go && (state_q == S_UPDATE) && (rd_index == lat_idx_q);
      if (rd_go) begin
        for (int j = 0; j < WEIGHT_NUMBER; j++) begin
          rd_weights[j] <= mem[rd_index][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_perceptron_weight_engine.sv
// tb/tb_perceptron_weight_engine.sv - self-checking bench for perceptron_weight_engine
module tb_perceptron_weight_engine;

  localparam int P  = 64;
  localparam int H  = 16;
  localparam int WN = 17;
  localparam int W  = 8;
  localparam int SW = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rd_en;
  logic [5:0]           rd_index;
  logic                 rd_valid;
  logic signed [W-1:0]  rd_weights [WN];
  logic                 rd_conflict;
  logic                 train_valid;
  logic                 train_ready;
  logic [5:0]           train_index;
  logic [H-1:0]         train_history;
  logic signed [SW-1:0] train_sum;
  logic                 train_taken;
  logic                 train_done;
  logic                 train_applied;

  always #5 clk = ~clk;

  perceptron_weight_engine dut (
    .clk           (clk),
    .rst           (rst),
    .rd_en         (rd_en),
    .rd_index      (rd_index),
    .rd_valid      (rd_valid),
    .rd_weights    (rd_weights),
    .rd_conflict   (rd_conflict),
    .train_valid   (train_valid),
    .train_ready   (train_ready),
    .train_index   (train_index),
    .train_history (train_history),
    .train_sum     (train_sum),
    .train_taken   (train_taken),
    .train_done    (train_done),
    .train_applied (train_applied)
  );

  typedef struct {
    logic [5:0]           idx;
    logic [H-1:0]         hist;
    logic signed [SW-1:0] sum;
    logic                 taken;
    int                   exp_applied;
    int                   w0;
    int                   w1;
    int                   w16;
  } vec_t;

  vec_t vecs [9];

  int n_cmp  = 0;
  int n_fail = 0;

  logic signed [W-1:0] rw [WN];
  int                  last_conflict;

  function automatic vec_t mk(input int idx, input int hist, input int sum, input int taken,
                              input int app, input int w0, input int w1, input int w16);
    vec_t v;
    v.idx         = 6'(idx);
    v.hist        = 16'(hist);
    v.sum         = 14'(sum);
    v.taken       = 1'(taken);
    v.exp_applied = app;
    v.w0          = w0;
    v.w1          = w1;
    v.w16         = w16;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_read(input int idx);
    @(negedge clk);
    rd_en    = 1'b1;
    rd_index = 6'(idx);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    @(negedge clk);
    check("rd_valid", int'(rd_valid), 1);
    last_conflict = int'(rd_conflict);
    for (int j = 0; j < WN; j++) rw[j] = rd_weights[j];
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!train_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (!train_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic do_train(input int idx, input int hist, input int sum, input int taken,
                          output int applied, output int lat, output int rlow);
    wait_ready();
    train_valid   = 1'b1;
    train_index   = 6'(idx);
    train_history = 16'(hist);
    train_sum     = 14'(sum);
    train_taken   = 1'(taken);
    @(posedge clk);
    #1;
    train_valid = 1'b0;
    lat  = 0;
    rlow = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!train_ready) rlow++;
    end while (!train_done && lat < 20);
    if (!train_done) check("done_timeout", 0, 1);
    applied = int'(train_applied);
  endtask

  task automatic count_clear(output int cnt, output int seen_done);
    cnt       = 0;
    seen_done = 0;
    while (!train_ready && cnt < 200) begin
      cnt++;
      if (train_done) seen_done = 1;
      @(negedge clk);
    end
  endtask

  int app, lat, rlow, cnt, seen, nz;

  initial begin
    vecs[0] = mk(10, 'h0001,     0, 1, 1,  1,  1, -1);
    vecs[1] = mk(11, 'h8000,     0, 0, 1, -1,  1, -1);
    vecs[2] = mk(12, 'hFFFF,    44, 1, 1,  1,  1,  1);
    vecs[3] = mk(13, 'hFFFF,    45, 1, 0,  0,  0,  0);
    vecs[4] = mk(14, 'hFFFF,   -45, 0, 0,  0,  0,  0);
    vecs[5] = mk(15, 'h0000,   -45, 1, 1,  1, -1, -1);
    vecs[6] = mk(16, 'h0000,   -44, 0, 1, -1,  1,  1);
    vecs[7] = mk(17, 'h0000, -8192, 0, 0,  0,  0,  0);
    vecs[8] = mk(18, 'h0002,  8191, 0, 1, -1,  1,  1);

    rst           = 1'b1;
    rd_en         = 1'b0;
    rd_index      = '0;
    train_valid   = 1'b0;
    train_index   = '0;
    train_history = '0;
    train_sum     = '0;
    train_taken   = 1'b0;

    // Reset values and CLEAR duration
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_train_ready", int'(train_ready), 0);
    check("rst_train_done", int'(train_done), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    nz = 0;
    for (int j = 0; j < WN; j++) if (rd_weights[j] != 0) nz++;
    check("rst_rd_weights_nonzero", nz, 0);
    rst = 1'b0;
    count_clear(cnt, seen);
    check("clear_cycles", cnt, 64);
    do_read(5);
    nz = 0;
    for (int j = 0; j < WN; j++) if (rw[j] != 0) nz++;
    check("row5_nonzero", nz, 0);

    // First training on row 3
    do_train(3, 'h0001, 0, 1, app, lat, rlow);
    check("t2_applied", app, 1);
    check("t2_latency", lat, 6);
    check("t2_ready_low", rlow, 5);
    do_read(3);
    check("t2_w0", int'(rw[0]), 1);
    check("t2_w1", int'(rw[1]), 1);
    check("t2_w2", int'(rw[2]), -1);
    check("t2_w16", int'(rw[16]), -1);

    // Correct and confident: no update
    do_train(3, 'h0001, 100, 1, app, lat, rlow);
    check("t3_applied", app, 0);
    check("t3_latency", lat, 1);
    check("t3_ready_low", rlow, 0);
    do_read(3);
    check("t3_w0", int'(rw[0]), 1);
    check("t3_w2", int'(rw[2]), -1);

    // Table-driven vectors on fresh rows
    for (int i = 0; i < 9; i++) begin
      do_train(int'(vecs[i].idx), int'(vecs[i].hist), int'(vecs[i].sum), int'(vecs[i].taken),
               app, lat, rlow);
      check($sformatf("vec%0d_applied", i), app, vecs[i].exp_applied);
      check($sformatf("vec%0d_latency", i), lat, (vecs[i].exp_applied != 0) ? 6 : 1);
      do_read(int'(vecs[i].idx));
      check($sformatf("vec%0d_w0", i), int'(rw[0]), vecs[i].w0);
      check($sformatf("vec%0d_w1", i), int'(rw[1]), vecs[i].w1);
      check($sformatf("vec%0d_w16", i), int'(rw[16]), vecs[i].w16);
    end

    // Saturation on row 3
    for (int k = 0; k < 200; k++) begin
      do_train(3, 'h0001, 0, 1, app, lat, rlow);
    end
    do_read(3);
    check("sat_w0", int'(rw[0]), 127);
    check("sat_w1", int'(rw[1]), 127);
    check("sat_w2", int'(rw[2]), -128);
    check("sat_w16", int'(rw[16]), -128);
    do_train(3, 'h0001, 0, 0, app, lat, rlow);
    check("unsat_applied", app, 1);
    do_read(3);
    check("unsat_w0", int'(rw[0]), 126);
    check("unsat_w1", int'(rw[1]), 126);
    check("unsat_w2", int'(rw[2]), -127);

    // Read during group 2 of a row-7 update
    wait_ready();
    train_valid   = 1'b1;
    train_index   = 6'd7;
    train_history = 16'h0001;
    train_sum     = -14'sd100;
    train_taken   = 1'b1;
    @(posedge clk);
    #1;
    train_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rd_en    = 1'b1;
    rd_index = 6'd7;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    @(negedge clk);
    check("t5_rd_valid", int'(rd_valid), 1);
    check("t5_rd_conflict", int'(rd_conflict), 1);
    check("t5_w0", int'(rd_weights[0]), 1);
    check("t5_w7", int'(rd_weights[7]), -1);
    check("t5_w8_old", int'(rd_weights[8]), 0);
    check("t5_w16_old", int'(rd_weights[16]), 0);
    @(negedge clk);
    check("t5_hold_valid", int'(rd_valid), 0);
    check("t5_hold_w0", int'(rd_weights[0]), 1);
    cnt = 0;
    while (!train_done && cnt < 10) begin
      cnt++;
      @(negedge clk);
    end
    check("t5_done_seen", int'(train_done), 1);
    check("t5_applied", int'(train_applied), 1);
    do_read(7);
    check("t5_after_w8", int'(rw[8]), -1);
    check("t5_after_conflict", last_conflict, 0);

    // Reset in the middle of a row-9 update
    wait_ready();
    train_valid   = 1'b1;
    train_index   = 6'd9;
    train_history = 16'hFFFF;
    train_sum     = '0;
    train_taken   = 1'b1;
    @(posedge clk);
    #1;
    train_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    count_clear(cnt, seen);
    check("t6_clear_cycles", cnt, 64);
    check("t6_no_done", seen, 0);
    do_read(9);
    nz = 0;
    for (int j = 0; j < WN; j++) if (rw[j] != 0) nz++;
    check("t6_row9_nonzero", nz, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
